mem_bus_interface: RTL and testbench

Single-port memory bus interface for the multi-cycle RISC-V core, sitting directly downstream of the controller FSM. It turns the controller's per-state memory requests (instruction fetch, load, store) into a valid/ready bus transaction, stalls the controller until the access completes, and owns the instruction register, old-PC register and read-data register that the decode and writeback states consume. Variable-latency memory, misaligned addresses and bus timeouts are absorbed here, so the controller keeps its fixed state sequence.

---
 rtl/mem_bus_interface_if.sv | 22 ++
 rtl/mem_bus_interface.sv | 134 +++++++++++++
 tb/tb_mem_bus_interface.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_interface_if.sv
// rtl/mem_bus_interface_if.sv - valid/ready memory bus bundle between the core interface and memory
interface mem_bus_interface_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - stalls the multi-cycle controller around one memory access and owns instr/old_pc/rdata
module mem_bus_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  req_ifetch,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] old_pc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_error,
  mem_bus_interface_if.master   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0]            CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(32'h0000_0013);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, old_pc_q, old_pc_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, instr_q, instr_d, rdata_q, rdata_d;
  logic                  write_q, write_d, ifetch_q, ifetch_d, err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  misaligned, timed_out;

  assign misaligned = req_addr[1:0] != 2'b00;
  // Ready on the last allowed cycle still wins over the abort.
  assign timed_out  = !bus.mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      pc_q     <= '0;
      old_pc_q <= '0;
      wdata_q  <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
      ifetch_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      wdata_q  <= wdata_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      write_q  <= write_d;
      ifetch_q <= ifetch_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = misaligned ? DONE : ACCESS;
      ACCESS:  if (bus.mem_ready || timed_out) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_d   = word_q;
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    wdata_d  = wdata_q;
    instr_d  = instr_q;
    rdata_d  = rdata_q;
    write_d  = write_q;
    ifetch_d = ifetch_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_d   = req_addr[ADDR_WIDTH-1:2];
          pc_d     = pc;
          wdata_d  = req_wdata;
          write_d  = req_write;
          ifetch_d = req_ifetch;
          cnt_d    = '0;
          if (misaligned) err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          if (!write_q) begin
            if (ifetch_q) begin
              instr_d  = bus.mem_rdata;
              old_pc_d = pc_q;
            end else begin
              rdata_d  = bus.mem_rdata;
            end
          end
        end else if (timed_out) begin
          // Aborted fetch decodes as a nop so the controller sequence stays intact.
          err_d = 1'b1;
          if (ifetch_q) instr_d = NOP;
          else          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall         = req_valid && (state_q != DONE);
    bus.mem_valid = state_q == ACCESS;
    bus.mem_we    = (state_q == ACCESS) && write_q;
  end

  assign bus.mem_addr  = {word_q, 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign instr         = instr_q;
  assign old_pc        = old_pc_q;
  assign rdata         = rdata_q;
  assign bus_error     = err_q;
endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - randomized and directed bench for mem_bus_interface with a transaction-level model
module tb_mem_bus_interface;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write, req_ifetch;
  logic [AW-1:0] req_addr, pc;
  logic [DW-1:0] req_wdata;
  logic          stall, bus_error;
  logic [DW-1:0] instr, rdata;
  logic [AW-1:0] old_pc;

  always #5 clk = ~clk;

  mem_bus_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mem_bus_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_ifetch(req_ifetch), .req_addr(req_addr), .req_wdata(req_wdata), .pc(pc),
    .stall(stall), .instr(instr), .old_pc(old_pc), .rdata(rdata),
    .bus_error(bus_error), .bus(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural view of the block: what each completed transaction leaves behind.
  logic [DW-1:0] m_instr, m_rdata;
  logic [AW-1:0] m_old_pc;
  logic          m_err;
  int            e_stall, e_valid;

  int            r_stall, r_valid, r_busbad;
  bit            r_hung;

  task automatic model_reset();
    m_instr = '0; m_rdata = '0; m_old_pc = '0; m_err = 1'b0;
  endtask

  // delay: ACCESS cycle in which memory answers, 0 = never answers.
  task automatic model_txn(input logic wr, input logic ifetch, input logic [AW-1:0] addr,
                           input logic [AW-1:0] pcv, input logic [DW-1:0] rd, input int delay);
    if (addr[1:0] != 2'b00) begin
      m_err = 1'b1; e_stall = 1; e_valid = 0;
    end else if (delay == 0 || delay > TO) begin
      m_err = 1'b1; e_stall = 1 + TO; e_valid = TO;
      if (ifetch) m_instr = 32'h0000_0013;
      else        m_rdata = '0;
    end else begin
      e_stall = 1 + delay; e_valid = delay;
      if (!wr) begin
        if (ifetch) begin m_instr = rd; m_old_pc = pcv; end
        else        m_rdata = rd;
      end
    end
  endtask

  // Acts as controller plus memory for one request; returns at posedge+1 after DONE.
  task automatic run_txn(input logic wr, input logic ifetch, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [AW-1:0] pcv,
                         input logic [DW-1:0] rd, input int delay, input bit noise);
    req_valid = 1'b1; req_write = wr; req_ifetch = ifetch;
    req_addr = addr; req_wdata = wdata; pc = pcv;
    r_stall = 0; r_valid = 0; r_busbad = 0; r_hung = 1'b1;
    bus_if.mem_ready = noise;
    bus_if.mem_rdata = DW'($urandom);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!stall) begin r_hung = 1'b0; break; end
      r_stall++;
      if (bus_if.mem_valid) begin
        r_valid++;
        if (bus_if.mem_addr !== {addr[AW-1:2], 2'b00} || bus_if.mem_we !== wr ||
            bus_if.mem_wdata !== wdata) r_busbad++;
        bus_if.mem_ready = (delay != 0) && (r_valid == delay);
        bus_if.mem_rdata = bus_if.mem_ready ? rd : DW'($urandom);
      end else begin
        bus_if.mem_ready = noise;
      end
    end
    if (r_hung) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_bound: stall still %b after 300 cycles, required 0", stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_if.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_ifetch = 1'b0;
    req_addr = '0; req_wdata = '0; pc = '0;
    bus_if.mem_ready = 1'b0; bus_if.mem_rdata = '0;
    model_reset();
    #1;
    n_cmp++; if (instr !== '0 || old_pc !== '0 || rdata !== '0) begin n_bad++;
      $display("FAIL reset_regs: instr %h old_pc %h rdata %h, required all 0", instr, old_pc, rdata); end
    n_cmp++; if (bus_if.mem_valid !== 1'b0 || bus_if.mem_we !== 1'b0 || bus_error !== 1'b0) begin n_bad++;
      $display("FAIL reset_flags: valid %b we %b err %b, required 0", bus_if.mem_valid, bus_if.mem_we, bus_error); end
    n_cmp++; if (bus_if.mem_addr !== '0 || bus_if.mem_wdata !== '0 || stall !== 1'b0) begin n_bad++;
      $display("FAIL reset_bus: addr %h wdata %h stall %b, required 0", bus_if.mem_addr, bus_if.mem_wdata, stall); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    model_txn(1'b0, 1'b1, 32'h10, 32'h10, 32'h0050_0093, 1);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 32'h10, 32'h0050_0093, 1, 1'b0);
    n_cmp++; if (r_stall !== 2) begin n_bad++; $display("FAIL fetch_stall: got %0d required 2", r_stall); end
    n_cmp++; if (instr !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_instr: got %h required 00500093", instr); end
    n_cmp++; if (old_pc !== 32'h10 || rdata !== 32'h0) begin n_bad++;
      $display("FAIL fetch_oldpc_rdata: old_pc %h rdata %h required 00000010 00000000", old_pc, rdata); end
  endtask

  task automatic test_load();
    model_txn(1'b0, 1'b0, 32'h100, 32'h14, 32'hDEAD_BEEF, 4);
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'h14, 32'hDEAD_BEEF, 4, 1'b0);
    n_cmp++; if (r_stall !== 5 || r_valid !== 4) begin n_bad++;
      $display("FAIL load_timing: stall %0d valid %0d required 5 4", r_stall, r_valid); end
    n_cmp++; if (r_busbad !== 0) begin n_bad++; $display("FAIL load_bus_stable: %0d bad cycles required 0", r_busbad); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF || instr !== 32'h0050_0093) begin n_bad++;
      $display("FAIL load_regs: rdata %h instr %h required deadbeef 00500093", rdata, instr); end
  endtask

  task automatic test_store();
    model_txn(1'b1, 1'b0, 32'h200, 32'h18, 32'hFFFF_FFFF, 2);
    run_txn(1'b1, 1'b0, 32'h200, 32'h1234_5678, 32'h18, 32'hFFFF_FFFF, 2, 1'b0);
    n_cmp++; if (r_stall !== 3 || r_valid !== 2 || r_busbad !== 0) begin n_bad++;
      $display("FAIL store_bus: stall %0d valid %0d bad %0d required 3 2 0", r_stall, r_valid, r_busbad); end
    n_cmp++; if (rdata !== m_rdata || instr !== m_instr || old_pc !== m_old_pc) begin n_bad++;
      $display("FAIL store_regs: rdata %h instr %h old_pc %h required %h %h %h", rdata, instr, old_pc, m_rdata, m_instr, m_old_pc); end
  endtask

  task automatic test_misaligned();
    logic [DW-1:0] d;
    model_txn(1'b0, 1'b0, 32'h102, 32'h1C, 32'h5555_AAAA, 1);
    run_txn(1'b0, 1'b0, 32'h102, 32'h0, 32'h1C, 32'h5555_AAAA, 1, 1'b0);
    n_cmp++; if (r_stall !== 1 || r_valid !== 0) begin n_bad++;
      $display("FAIL misaligned_timing: stall %0d valid %0d required 1 0", r_stall, r_valid); end
    n_cmp++; if (bus_error !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin n_bad++;
      $display("FAIL misaligned_regs: err %b rdata %h required 1 deadbeef", bus_error, rdata); end
    d = DW'($urandom);
    model_txn(1'b0, 1'b0, 32'h104, 32'h20, d, 1);
    run_txn(1'b0, 1'b0, 32'h104, 32'h0, 32'h20, d, 1, 1'b0);
    n_cmp++; if (bus_error !== 1'b1 || rdata !== d) begin n_bad++;
      $display("FAIL error_sticky: err %b rdata %h required 1 %h", bus_error, rdata, d); end
  endtask

  task automatic test_timeout();
    model_txn(1'b0, 1'b1, 32'h24, 32'h24, 32'h0, 0);
    run_txn(1'b0, 1'b1, 32'h24, 32'h0, 32'h24, 32'h0, 0, 1'b0);
    n_cmp++; if (r_valid !== TO || r_stall !== TO + 1) begin n_bad++;
      $display("FAIL timeout_timing: valid %0d stall %0d required %0d %0d", r_valid, r_stall, TO, TO + 1); end
    n_cmp++; if (instr !== 32'h0000_0013 || bus_error !== 1'b1 || old_pc !== m_old_pc) begin n_bad++;
      $display("FAIL timeout_regs: instr %h err %b old_pc %h required 00000013 1 %h", instr, bus_error, old_pc, m_old_pc); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, p;
    logic [DW-1:0] wd, rd;
    logic          wr, fe;
    int            kind, dly, gap;
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      wr = kind == 2; fe = kind == 0;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      p = $urandom; wd = $urandom; rd = $urandom;
      dly = int'($urandom_range(0, 6));
      model_txn(wr, fe, a, p, rd, dly);
      run_txn(wr, fe, a, wd, p, rd, dly, 1'($urandom_range(0, 1)));
      n_cmp++; if (r_stall !== e_stall || r_valid !== e_valid || r_busbad !== 0) begin n_bad++;
        $display("FAIL rand_timing[%0d]: stall %0d valid %0d bad %0d required %0d %0d 0", t, r_stall, r_valid, r_busbad, e_stall, e_valid); end
      n_cmp++; if (instr !== m_instr || old_pc !== m_old_pc || rdata !== m_rdata || bus_error !== m_err) begin n_bad++;
        $display("FAIL rand_regs[%0d]: instr %h old_pc %h rdata %h err %b required %h %h %h %b", t, instr, old_pc, rdata, bus_error, m_instr, m_old_pc, m_rdata, m_err); end
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_access();
    bit seen = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_ifetch = 1'b1; req_addr = 32'h30; pc = 32'h30;
    bus_if.mem_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_if.mem_valid) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rst_mid_start: mem_valid %b required 1", bus_if.mem_valid); end
    #2 reset = 1'b0;
    req_valid = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bus_if.mem_valid !== 1'b0 || instr !== '0 || rdata !== '0 || bus_error !== 1'b0 || old_pc !== '0) begin n_bad++;
      $display("FAIL rst_mid_clear: valid %b instr %h rdata %h err %b old_pc %h required all 0", bus_if.mem_valid, instr, rdata, bus_error, old_pc); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_txn(1'b0, 1'b1, 32'h40, 32'h40, 32'h0010_0113, 2);
    run_txn(1'b0, 1'b1, 32'h40, 32'h0, 32'h40, 32'h0010_0113, 2, 1'b0);
    n_cmp++; if (instr !== 32'h0010_0113 || old_pc !== 32'h40 || bus_error !== 1'b0 || r_stall !== 3) begin n_bad++;
      $display("FAIL rst_mid_refetch: instr %h old_pc %h err %b stall %0d required 00100113 00000040 0 3", instr, old_pc, bus_error, r_stall); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
